// File: rtl/riscv_mem_responder_pkg.sv
// Shared definitions for the RISCV32I memory responder: FSM states, port ids
// and the width of the latency counter.
package riscv_mem_responder_pkg;

    // Wide enough for the largest legal LATENCY (15).
    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        PORT_FETCH = 2'd0,
        PORT_LOAD  = 2'd1,
        PORT_STORE = 2'd2
    } port_e;

endpackage

// File: rtl/riscv_mem_responder_if.sv
// Fetch / load / store request-acknowledge bundle between the core and the memory responder.
// Handshake: a requester raises *_req with its address/data and holds them until the matching
// one-cycle *_ack; err and the returned word are valid only in that ack cycle, and req must be
// dropped on the ack edge or it is taken as a new request.
interface riscv_mem_responder_if #(
    parameter int XLEN = 32
);
    logic            fetch_req;
    logic [XLEN-1:0] instr_fetch_addr;
    logic [XLEN-1:0] instruction;
    logic            fetch_ack;

    logic            load_req;
    logic [XLEN-1:0] read_addr;
    logic [XLEN-1:0] read_data;
    logic            load_ack;

    logic            store_req;
    logic [XLEN-1:0] write_addr;
    logic [XLEN-1:0] write_data;
    logic [3:0]      write_strb;
    logic            store_ack;

    logic            err;
    logic            busy;

    modport master (
        output fetch_req, instr_fetch_addr, load_req, read_addr,
               store_req, write_addr, write_data, write_strb,
        input  instruction, fetch_ack, read_data, load_ack, store_ack, err, busy
    );

    modport slave (
        input  fetch_req, instr_fetch_addr, load_req, read_addr,
               store_req, write_addr, write_data, write_strb,
        output instruction, fetch_ack, read_data, load_ack, store_ack, err, busy
    );

endinterface

// File: rtl/riscv_mem_responder_mem_array_1p.sv
// Single-port synchronous word RAM with per-byte write strobes and a registered read.
// Contents and read register are deliberately not reset.
module mem_array_1p #(
    parameter int DW    = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            en_i,
    input  logic            we_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [DW-1:0]   wdata_i,
    input  logic [DW/8-1:0] strb_i,
    output logic [DW-1:0]   rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < DW/8; i++) begin
                    if (strb_i[i]) begin
                        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end else begin
                rdata_o <= mem_q[addr_i];
            end
        end
    end

endmodule

// File: rtl/riscv_mem_responder.sv
// Memory-side responder for the core's fetch and load/store ports: fixed-priority arbiter,
// programmable-latency IDLE/WAIT/RESP FSM and range/alignment error checks over one shared RAM.
module riscv_mem_responder
    import riscv_mem_responder_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    riscv_mem_responder_if.slave        bus,
    output state_e                      dbg_state_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_e            state_q, state_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    port_e             port_q;
    logic [XLEN-1:0]   addr_q, wdata_q;
    logic [3:0]        strb_q;
    logic              err_q;
    logic [XLEN-1:0]   instr_q, rdata_q;

    logic              sel_valid;
    port_e             sel_port;
    logic [XLEN-1:0]   sel_addr, sel_wdata;
    logic [3:0]        sel_strb;

    port_e             cur_port;
    logic [XLEN-1:0]   cur_addr, cur_wdata;
    logic [3:0]        cur_strb;
    logic              cur_err;

    logic              ram_en;
    logic [XLEN-1:0]   ram_rdata;
    logic              resp, fetch_ack, load_ack, store_ack;
    logic [XLEN-1:0]   rd_word, instr_out, rdata_out;

    // Fixed priority: store > load > fetch.
    always_comb begin
        sel_valid = 1'b1;
        sel_port  = PORT_FETCH;
        sel_addr  = bus.instr_fetch_addr;
        sel_wdata = '0;
        sel_strb  = '0;
        if (bus.store_req) begin
            sel_port  = PORT_STORE;
            sel_addr  = bus.write_addr;
            sel_wdata = bus.write_data;
            sel_strb  = bus.write_strb;
        end else if (bus.load_req) begin
            sel_port  = PORT_LOAD;
            sel_addr  = bus.read_addr;
        end else if (!bus.fetch_req) begin
            sel_valid = 1'b0;
        end
    end

    // With LATENCY == 1 the array is accessed on the accept edge itself, so the live
    // selection is used in IDLE and the latched request everywhere else.
    always_comb begin
        cur_port  = (state_q == ST_IDLE) ? sel_port  : port_q;
        cur_addr  = (state_q == ST_IDLE) ? sel_addr  : addr_q;
        cur_wdata = (state_q == ST_IDLE) ? sel_wdata : wdata_q;
        cur_strb  = (state_q == ST_IDLE) ? sel_strb  : strb_q;
        cur_err   = (|cur_addr[XLEN-1:AW+2]) ||
                    ((cur_port == PORT_FETCH) && (cur_addr[1:0] != 2'b00));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    if (LATENCY > 1) begin
                        state_d = ST_WAIT;
                        cnt_d   = LAT_W'(LATENCY - 1);
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == LAT_W'(1)) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A reset on the commit edge must not let a store reach the array.
    assign ram_en = (state_d == ST_RESP) && (state_q != ST_RESP) && !cur_err && !rst;

    mem_array_1p #(
        .DW    (XLEN),
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk),
        .en_i    (ram_en),
        .we_i    (cur_port == PORT_STORE),
        .addr_i  (cur_addr[AW+1:2]),
        .wdata_i (cur_wdata),
        .strb_i  (cur_strb),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            port_q  <= PORT_FETCH;
            err_q   <= 1'b0;
            instr_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if ((state_q == ST_IDLE) && sel_valid) begin
                port_q <= sel_port;
                err_q  <= cur_err;
            end
            if (fetch_ack) instr_q <= instr_out;
            if (load_ack)  rdata_q <= rdata_out;
        end
    end

    always_ff @(posedge clk) begin
        if ((state_q == ST_IDLE) && sel_valid) begin
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            strb_q  <= sel_strb;
        end
    end

    assign resp      = (state_q == ST_RESP);
    assign fetch_ack = resp && (port_q == PORT_FETCH);
    assign load_ack  = resp && (port_q == PORT_LOAD);
    assign store_ack = resp && (port_q == PORT_STORE);
    assign rd_word   = err_q ? '0 : ram_rdata;
    assign instr_out = fetch_ack ? rd_word : instr_q;
    assign rdata_out = load_ack  ? rd_word : rdata_q;

    assign bus.fetch_ack   = fetch_ack;
    assign bus.load_ack    = load_ack;
    assign bus.store_ack   = store_ack;
    assign bus.instruction = instr_out;
    assign bus.read_data   = rdata_out;
    assign bus.err         = resp && err_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Directed bench for riscv_mem_responder at LATENCY 1, 4 and 3 with hand-computed expectations.
module tb_riscv_mem_responder;
    import riscv_mem_responder_pkg::*;

    localparam int K_FETCH = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int dsel     = 1;

    logic        t_fetch_req = 0, t_load_req = 0, t_store_req = 0;
    logic [31:0] t_faddr = 0, t_raddr = 0, t_waddr = 0, t_wdata = 0;
    logic [3:0]  t_wstrb = 0;

    riscv_mem_responder_if #(.XLEN(32)) bus1 ();
    riscv_mem_responder_if #(.XLEN(32)) bus4 ();
    riscv_mem_responder_if #(.XLEN(32)) bus3 ();
    state_e dbg1, dbg4, dbg3;

    assign bus1.fetch_req = t_fetch_req && (dsel == 1);
    assign bus1.load_req  = t_load_req  && (dsel == 1);
    assign bus1.store_req = t_store_req && (dsel == 1);
    assign bus4.fetch_req = t_fetch_req && (dsel == 4);
    assign bus4.load_req  = t_load_req  && (dsel == 4);
    assign bus4.store_req = t_store_req && (dsel == 4);
    assign bus3.fetch_req = t_fetch_req && (dsel == 3);
    assign bus3.load_req  = t_load_req  && (dsel == 3);
    assign bus3.store_req = t_store_req && (dsel == 3);
    assign bus1.instr_fetch_addr = t_faddr; assign bus4.instr_fetch_addr = t_faddr; assign bus3.instr_fetch_addr = t_faddr;
    assign bus1.read_addr  = t_raddr; assign bus4.read_addr  = t_raddr; assign bus3.read_addr  = t_raddr;
    assign bus1.write_addr = t_waddr; assign bus4.write_addr = t_waddr; assign bus3.write_addr = t_waddr;
    assign bus1.write_data = t_wdata; assign bus4.write_data = t_wdata; assign bus3.write_data = t_wdata;
    assign bus1.write_strb = t_wstrb; assign bus4.write_strb = t_wstrb; assign bus3.write_strb = t_wstrb;

    riscv_mem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .bus(bus1.slave), .dbg_state_o(dbg1));
    riscv_mem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .bus(bus4.slave), .dbg_state_o(dbg4));
    riscv_mem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .bus(bus3.slave), .dbg_state_o(dbg3));

    // Observation mux onto whichever DUT is currently selected.
    logic        o_fack, o_lack, o_sack, o_err, o_busy;
    logic [31:0] o_instr, o_rdata;
    state_e      o_dbg;
    always_comb begin
        case (dsel)
            4: begin
                o_fack = bus4.fetch_ack; o_lack = bus4.load_ack; o_sack = bus4.store_ack;
                o_err = bus4.err; o_busy = bus4.busy; o_instr = bus4.instruction;
                o_rdata = bus4.read_data; o_dbg = dbg4;
            end
            3: begin
                o_fack = bus3.fetch_ack; o_lack = bus3.load_ack; o_sack = bus3.store_ack;
                o_err = bus3.err; o_busy = bus3.busy; o_instr = bus3.instruction;
                o_rdata = bus3.read_data; o_dbg = dbg3;
            end
            default: begin
                o_fack = bus1.fetch_ack; o_lack = bus1.load_ack; o_sack = bus1.store_ack;
                o_err = bus1.err; o_busy = bus1.busy; o_instr = bus1.instruction;
                o_rdata = bus1.read_data; o_dbg = dbg1;
            end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait (bounded) for its ack; lat = negedges after the accept edge, -1 on timeout.
    task automatic do_req(input int kind, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] strb, output logic [31:0] data,
                          output logic e, output int lat);
        logic hit;
        @(negedge clk);
        case (kind)
            K_FETCH: begin t_fetch_req = 1; t_faddr = addr; end
            K_LOAD:  begin t_load_req = 1;  t_raddr = addr; end
            default: begin t_store_req = 1; t_waddr = addr; t_wdata = wd; t_wstrb = strb; end
        endcase
        lat = -1; data = '0; e = 1'bx;
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            hit = (kind == K_FETCH) ? o_fack : (kind == K_LOAD) ? o_lack : o_sack;
            if (hit) begin
                lat = n; e = o_err;
                data = (kind == K_FETCH) ? o_instr : o_rdata;
                break;
            end
        end
        t_fetch_req = 0; t_load_req = 0; t_store_req = 0;
        @(posedge clk);
    endtask

    logic [31:0] d, fdata, ldata;
    logic        e, seen;
    int          l, ln, fn, lc, fc;
    logic [9:0]  ack_pat, busy_pat;
    int          ds [3] = '{1, 4, 3};

    initial begin
        // Reset state of all three instances.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            dsel = ds[i];
            #1;
            check($sformatf("rst_acks_%0d", ds[i]), {29'd0, o_fack, o_lack, o_sack}, 32'd0);
            check($sformatf("rst_err_busy_%0d", ds[i]), {30'd0, o_err, o_busy}, 32'd0);
            check($sformatf("rst_instr_%0d", ds[i]), o_instr, 32'd0);
            check($sformatf("rst_rdata_%0d", ds[i]), o_rdata, 32'd0);
            check($sformatf("rst_state_%0d", ds[i]), {30'd0, o_dbg}, {30'd0, ST_IDLE});
        end
        rst = 0;

        // LATENCY=1: full-word store and load back.
        dsel = 1;
        do_req(K_STORE, 32'h10, 32'hDEADBEEF, 4'hF, d, e, l);
        check("l1_store_lat", l, 1);
        check("l1_store_err", {31'd0, e}, 0);
        do_req(K_LOAD, 32'h10, 0, 0, d, e, l);
        check("l1_load_lat", l, 1);
        check("l1_load_data", d, 32'hDEADBEEF);
        check("l1_load_err", {31'd0, e}, 0);
        @(negedge clk);
        check("l1_rdata_hold", o_rdata, 32'hDEADBEEF);

        // Partial strobe: lanes 0 and 2 replaced.
        do_req(K_STORE, 32'h20, 32'h11223344, 4'hF, d, e, l);
        do_req(K_STORE, 32'h20, 32'hAABBCCDD, 4'b0101, d, e, l);
        do_req(K_LOAD, 32'h20, 0, 0, d, e, l);
        check("l1_partial_data", d, 32'h11BB33DD);

        // Zero strobe writes nothing; load ignores addr[1:0].
        do_req(K_STORE, 32'h10, 32'h0, 4'h0, d, e, l);
        check("l1_strb0_err", {31'd0, e}, 0);
        do_req(K_LOAD, 32'h13, 0, 0, d, e, l);
        check("l1_strb0_unaligned_load", d, 32'hDEADBEEF);

        // Errors: misaligned fetch and out-of-range store.
        do_req(K_STORE, 32'h0, 32'h00000013, 4'hF, d, e, l);
        do_req(K_FETCH, 32'h0, 0, 0, d, e, l);
        check("l1_fetch_data", d, 32'h00000013);
        do_req(K_FETCH, 32'h2, 0, 0, d, e, l);
        check("l1_misfetch_err", {31'd0, e}, 1);
        check("l1_misfetch_data", d, 32'h0);
        do_req(K_STORE, 32'h1000, 32'h12345678, 4'hF, d, e, l);
        check("l1_oor_store_lat", l, 1);
        check("l1_oor_store_err", {31'd0, e}, 1);
        do_req(K_LOAD, 32'h0, 0, 0, d, e, l);
        check("l1_word0_intact", d, 32'h00000013);
        check("l1_word0_err", {31'd0, e}, 0);

        // LATENCY=4: latency, busy window and back-to-back spacing.
        dsel = 4;
        do_req(K_STORE, 32'h0, 32'h00000093, 4'hF, d, e, l);
        check("l4_store_lat", l, 4);
        do_req(K_FETCH, 32'h0, 0, 0, d, e, l);
        check("l4_fetch_lat", l, 4);
        check("l4_fetch_data", d, 32'h00000093);
        @(negedge clk);
        t_fetch_req = 1; t_faddr = 32'h0;
        @(posedge clk);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            ack_pat[n-1]  = o_fack;
            busy_pat[n-1] = o_busy;
            if (n == 9) t_fetch_req = 0;
        end
        check("l4_ack_pattern", {22'd0, ack_pat}, 32'h108);
        check("l4_busy_pattern", {22'd0, busy_pat}, 32'h1EF);

        // Simultaneous fetch and load: load wins, fetch follows, one ack each.
        do_req(K_STORE, 32'h4, 32'hA0A0A0A0, 4'hF, d, e, l);
        do_req(K_STORE, 32'h8, 32'hB0B0B0B0, 4'hF, d, e, l);
        @(negedge clk);
        t_fetch_req = 1; t_faddr = 32'h4; t_load_req = 1; t_raddr = 32'h8;
        ln = 0; fn = 0; lc = 0; fc = 0; ldata = 0; fdata = 0;
        @(posedge clk);
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (o_lack) begin lc++; if (ln == 0) ln = n; ldata = o_rdata; t_load_req = 0; end
            if (o_fack) begin fc++; if (fn == 0) fn = n; fdata = o_instr; t_fetch_req = 0; end
        end
        t_fetch_req = 0; t_load_req = 0;
        check("l4_sim_load_at", ln, 4);
        check("l4_sim_fetch_at", fn, 9);
        check("l4_sim_load_count", lc, 1);
        check("l4_sim_fetch_count", fc, 1);
        check("l4_sim_load_data", ldata, 32'hB0B0B0B0);
        check("l4_sim_fetch_data", fdata, 32'hA0A0A0A0);

        // LATENCY=3: reset during WAIT of a store.
        dsel = 3;
        do_req(K_STORE, 32'h30, 32'h55AA55AA, 4'hF, d, e, l);
        check("l3_store_lat", l, 3);
        do_req(K_LOAD, 32'h30, 0, 0, d, e, l);
        check("l3_load_data", d, 32'h55AA55AA);
        @(negedge clk);
        t_store_req = 1; t_waddr = 32'h30; t_wdata = 32'hFFFFFFFF; t_wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        check("l3_busy_in_wait", {31'd0, o_busy}, 1);
        check("l3_state_wait", {30'd0, o_dbg}, {30'd0, ST_WAIT});
        rst = 1; t_store_req = 0;
        @(posedge clk);
        @(negedge clk);
        check("l3_rst_acks", {29'd0, o_fack, o_lack, o_sack}, 0);
        check("l3_rst_err_busy", {30'd0, o_err, o_busy}, 0);
        check("l3_rst_rdata", o_rdata, 0);
        check("l3_rst_instr", o_instr, 0);
        rst = 0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | o_sack;
        end
        check("l3_no_store_ack", {31'd0, seen}, 0);
        do_req(K_FETCH, 32'h30, 0, 0, d, e, l);
        check("l3_post_rst_fetch_lat", l, 3);
        check("l3_post_rst_fetch_data", d, 32'h55AA55AA);
        check("l3_post_rst_fetch_err", {31'd0, e}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
